bin2bcd_serial: RTL

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm; performs the inverse of the team's BCD-to-binary digit combiner.
- Accepts an unsigned binary value through a start/busy/done handshake and returns hundreds, tens and units BCD digits.
- Sits in front of seven-segment and display-formatting logic.
- Processes one bit per clock, trading latency for area.

---
 rtl/bin2bcd_serial_if.sv | 33 +++
 rtl/bin2bcd_serial.sv | 98 +++++++++
 2 files changed

// File: rtl/bin2bcd_serial_if.sv
// Start/busy/done handshake and BCD digit bundle for bin2bcd_serial.
// The master drives the operand; the slave (converter) returns status and digits.
interface bin2bcd_serial_if #(
  parameter int unsigned WIDTH = 7
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       D2;
  logic [3:0]       D1;
  logic [3:0]       D0;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  D2,
    input  D1,
    input  D0
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output D2,
    output D1,
    output D0
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 (double-dabble) binary to three-digit BCD converter.
// One operand bit per clock; digits are registered only when a conversion completes.
module bin2bcd_serial #(
  parameter int unsigned WIDTH = 7
) (
  input logic              clk,
  input logic              rst,
  bin2bcd_serial_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [11:0]      r_acc;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_cnt;
  logic [3:0]       r_d2;
  logic [3:0]       r_d1;
  logic [3:0]       r_d0;

  logic [11:0]      w_acc_adj;
  logic [11:0]      w_acc_shift;
  logic             w_last;

  // All three digits are corrected from the same pre-add accumulator value.
  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < 3; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
    w_acc_shift = (w_acc_adj << 1) | 12'(r_shift[WIDTH-1]);
    w_last      = (r_cnt == 4'(WIDTH - 1));
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_next = StShift;
      StShift: if (w_last)    w_state_next = StDone;
      StDone:                 w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_d2    <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_shift <= bus.bin;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        StShift: begin
          r_acc   <= w_acc_shift;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 4'd1;
          if (w_last) begin
            r_d2 <= w_acc_shift[11:8];
            r_d1 <= w_acc_shift[7:4];
            r_d0 <= w_acc_shift[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != StIdle);
  assign bus.done = (r_state == StDone);
  assign bus.D2   = r_d2;
  assign bus.D1   = r_d1;
  assign bus.D0   = r_d0;

endmodule
